// File: rtl/mips_multicycle_control_if.sv
// mips_multicycle_control_if: control-FSM bus; the datapath side (master) drives
// enable/opcode/mem_ready and receives the strobes, selects, state and counters.
interface mips_multicycle_control_if #(
  parameter int COUNT_WIDTH = 16
);
  logic                   enable_i;
  logic [5:0]             opcode_i;
  logic                   mem_ready_i;
  logic                   mem_req_o;
  logic                   ir_write_o;
  logic                   pc_write_o;
  logic                   branch_eq_o;
  logic                   branch_ne_o;
  logic                   pc_src_o;
  logic                   alu_src_a_o;
  logic [1:0]             alu_src_b_o;
  logic [2:0]             alu_op_o;
  logic                   reg_dst_o;
  logic                   reg_write_o;
  logic [2:0]             state_o;
  logic                   illegal_o;
  logic [COUNT_WIDTH-1:0] retired_o;
  modport master (
    output enable_i, opcode_i, mem_ready_i,
    input  mem_req_o, ir_write_o, pc_write_o, branch_eq_o, branch_ne_o, pc_src_o,
           alu_src_a_o, alu_src_b_o, alu_op_o, reg_dst_o, reg_write_o, state_o,
           illegal_o, retired_o
  );
  modport slave (
    input  enable_i, opcode_i, mem_ready_i,
    output mem_req_o, ir_write_o, pc_write_o, branch_eq_o, branch_ne_o, pc_src_o,
           alu_src_a_o, alu_src_b_o, alu_op_o, reg_dst_o, reg_write_o, state_o,
           illegal_o, retired_o
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multicycle MIPS main control FSM (fetch/decode/exec/wb/branch).
// Ports: clk, reset (sync, active-low); bus (slave) carries enable/opcode/mem_ready in,
// datapath strobes and mux selects, state, sticky illegal flag and retired count out.
module mips_multicycle_control #(
  parameter int COUNT_WIDTH = 16
) (
  input logic                        clk,
  input logic                        reset,
  mips_multicycle_control_if.slave   bus
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC_R, EXEC_I, WB, BRANCH, TRAP} state_t;
  typedef struct packed {
    logic       mem_req;
    logic       branch_eq;
    logic       branch_ne;
    logic       pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_dst;
    logic       reg_write;
  } ctrl_t;
  state_t                 state_q, state_d;
  ctrl_t                  ctrl_q, ctrl_d;
  logic                   illegal_q;
  logic [COUNT_WIDTH-1:0] retired_q;
  // Outputs are registered by decoding the state being entered; opcode_i is
  // already stable one cycle before every opcode-dependent state.
  function automatic ctrl_t decode(state_t s, logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_req   = 1'b1;
        c.alu_src_b = 2'b01;
      end
      DECODE: c.alu_src_b = 2'b11;
      EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 3'b010;
      end
      EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = op == 6'h0D ? 3'b011 : 3'b000;
      end
      WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = op == 6'h00;
      end
      BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 3'b001;
        c.pc_src    = 1'b1;
        c.branch_eq = op == 6'h04;
        c.branch_ne = op == 6'h05;
      end
      default: c = '0;
    endcase
    return c;
  endfunction
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:           state_d = bus.enable_i ? FETCH : IDLE;
      FETCH:          state_d = bus.mem_ready_i ? DECODE : FETCH;
      DECODE:         state_d = bus.opcode_i == 6'h00 ? EXEC_R :
                                (bus.opcode_i == 6'h08 || bus.opcode_i == 6'h0D) ? EXEC_I :
                                (bus.opcode_i == 6'h04 || bus.opcode_i == 6'h05) ? BRANCH : TRAP;
      EXEC_R, EXEC_I: state_d = WB;
      WB, BRANCH:     state_d = bus.enable_i ? FETCH : IDLE;
      default:        state_d = TRAP;
    endcase
    ctrl_d = decode(state_d, bus.opcode_i);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_q | (state_d == TRAP);
      retired_q <= retired_q + COUNT_WIDTH'(state_q == WB || state_q == BRANCH);
    end
  end
  // IR and PC load only on the FETCH cycle where memory delivers data.
  assign bus.mem_req_o   = ctrl_q.mem_req;
  assign bus.ir_write_o  = ctrl_q.mem_req & bus.mem_ready_i;
  assign bus.pc_write_o  = ctrl_q.mem_req & bus.mem_ready_i;
  assign bus.branch_eq_o = ctrl_q.branch_eq;
  assign bus.branch_ne_o = ctrl_q.branch_ne;
  assign bus.pc_src_o    = ctrl_q.pc_src;
  assign bus.alu_src_a_o = ctrl_q.alu_src_a;
  assign bus.alu_src_b_o = ctrl_q.alu_src_b;
  assign bus.alu_op_o    = ctrl_q.alu_op;
  assign bus.reg_dst_o   = ctrl_q.reg_dst;
  assign bus.reg_write_o = ctrl_q.reg_write;
  assign bus.state_o     = state_q;
  assign bus.illegal_o   = illegal_q;
  assign bus.retired_o   = retired_q;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: directed cycle vectors pushed to a scoreboard, checked by a negedge monitor.
module tb_mips_multicycle_control;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  mips_multicycle_control_if #(.COUNT_WIDTH(16)) b ();
  mips_multicycle_control_if #(.COUNT_WIDTH(2))  b2 ();
  mips_multicycle_control #(.COUNT_WIDTH(16)) dut (.clk(clk), .reset(reset), .bus(b.slave));
  mips_multicycle_control #(.COUNT_WIDTH(2))  dut2 (.clk(clk), .reset(reset), .bus(b2.slave));
  assign b2.enable_i    = b.enable_i;
  assign b2.opcode_i    = b.opcode_i;
  assign b2.mem_ready_i = b.mem_ready_i;
  typedef struct {
    string       nm;
    logic [35:0] v;
  } ent_t;
  ent_t        q[$];
  ent_t        e;
  int          checks = 0;
  int          errors = 0;
  logic [35:0] obs;
  assign obs = {b.state_o, b.mem_req_o, b.ir_write_o, b.pc_write_o, b.branch_eq_o, b.branch_ne_o,
                b.pc_src_o, b.alu_src_a_o, b.alu_src_b_o, b.alu_op_o, b.reg_dst_o, b.reg_write_o,
                b.illegal_o, b.retired_o, b2.retired_o};
  // Spec output table: {mem_req, ir_write, pc_write, beq, bne, pc_src, src_a, src_b, alu_op, reg_dst, reg_write}
  function automatic logic [13:0] exp_ctrl(logic [2:0] st, logic [5:0] op, logic rdy);
    case (st)
      3'd1:    return {1'b1, rdy, rdy, 3'b000, 1'b0, 2'b01, 3'b000, 2'b00};
      3'd2:    return {6'b0, 1'b0, 2'b11, 3'b000, 2'b00};
      3'd3:    return {6'b0, 1'b1, 2'b00, 3'b010, 2'b00};
      3'd4:    return {6'b0, 1'b1, 2'b10, (op == 6'h0D) ? 3'b011 : 3'b000, 2'b00};
      3'd5:    return {6'b0, 1'b0, 2'b00, 3'b000, op == 6'h00, 1'b1};
      3'd6:    return {3'b000, op == 6'h04, op == 6'h05, 1'b1, 1'b1, 2'b00, 3'b001, 2'b00};
      default: return 14'd0;
    endcase
  endfunction
  task automatic cyc(input string nm, input bit rn, input bit en, input bit rdy, input logic [5:0] op,
                     input logic [2:0] st, input logic [15:0] rt, input logic [1:0] r2, input bit il);
    ent_t x;
    @(posedge clk);
    #1;
    reset = rn;
    b.enable_i = en;
    b.mem_ready_i = rdy;
    b.opcode_i = op;
    x.nm = nm;
    x.v = {st, exp_ctrl(st, op, rdy), il, rt, r2};
    q.push_back(x);
  endtask
  always @(negedge clk) begin
    if (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.nm, obs, e.v);
      end
    end
  end
  initial begin
    b.enable_i = 1'b0;
    b.mem_ready_i = 1'b1;
    b.opcode_i = 6'h00;
    repeat (2) @(posedge clk);
    cyc("reset",      1, 0, 1, 6'h00, 3'd0, 0, 0, 0);
    cyc("idle_go",    1, 1, 1, 6'h00, 3'd0, 0, 0, 0);
    cyc("r_fetch",    1, 1, 1, 6'h00, 3'd1, 0, 0, 0);
    cyc("r_decode",   1, 1, 1, 6'h00, 3'd2, 0, 0, 0);
    cyc("r_exec",     1, 1, 1, 6'h00, 3'd3, 0, 0, 0);
    cyc("r_wb",       1, 1, 1, 6'h00, 3'd5, 0, 0, 0);
    cyc("addi_fetch", 1, 1, 1, 6'h08, 3'd1, 1, 1, 0);
    cyc("addi_dec",   1, 1, 1, 6'h08, 3'd2, 1, 1, 0);
    cyc("addi_exec",  1, 1, 1, 6'h08, 3'd4, 1, 1, 0);
    cyc("addi_wb",    1, 1, 1, 6'h08, 3'd5, 1, 1, 0);
    cyc("ori_fetch",  1, 1, 1, 6'h0D, 3'd1, 2, 2, 0);
    cyc("ori_dec",    1, 1, 1, 6'h0D, 3'd2, 2, 2, 0);
    cyc("ori_exec",   1, 1, 1, 6'h0D, 3'd4, 2, 2, 0);
    cyc("ori_wb",     1, 1, 1, 6'h0D, 3'd5, 2, 2, 0);
    cyc("beq_fetch",  1, 1, 1, 6'h04, 3'd1, 3, 3, 0);
    cyc("beq_dec",    1, 1, 1, 6'h04, 3'd2, 3, 3, 0);
    cyc("beq_branch", 1, 1, 1, 6'h04, 3'd6, 3, 3, 0);
    cyc("bne_fetch",  1, 1, 1, 6'h05, 3'd1, 4, 0, 0);
    cyc("bne_dec",    1, 1, 1, 6'h05, 3'd2, 4, 0, 0);
    cyc("bne_branch", 1, 1, 1, 6'h05, 3'd6, 4, 0, 0);
    for (int i = 0; i < 5; i++)
      cyc("fetch_wait", 1, 1, 0, 6'h00, 3'd1, 5, 1, 0);
    cyc("fetch_ready", 1, 1, 1, 6'h00, 3'd1, 5, 1, 0);
    cyc("wait_dec",    1, 1, 1, 6'h00, 3'd2, 5, 1, 0);
    cyc("drop_exec",   1, 0, 1, 6'h00, 3'd3, 5, 1, 0);
    cyc("drop_wb",     1, 0, 1, 6'h00, 3'd5, 5, 1, 0);
    cyc("park_idle",   1, 0, 1, 6'h00, 3'd0, 6, 2, 0);
    cyc("restart",     1, 1, 1, 6'h00, 3'd0, 6, 2, 0);
    cyc("bad_fetch",   1, 1, 1, 6'h23, 3'd1, 6, 2, 0);
    cyc("bad_dec",     1, 1, 1, 6'h23, 3'd2, 6, 2, 0);
    for (int i = 0; i < 10; i++)
      cyc("trap_hold", 1, 1, 1, 6'h23, 3'd7, 6, 2, 1);
    cyc("trap_rst",    0, 1, 1, 6'h23, 3'd7, 6, 2, 1);
    cyc("trap_clear",  1, 0, 1, 6'h00, 3'd0, 0, 0, 0);
    cyc("go2",         1, 1, 1, 6'h00, 3'd0, 0, 0, 0);
    cyc("go2_fetch",   1, 1, 1, 6'h00, 3'd1, 0, 0, 0);
    cyc("dec_rst",     0, 1, 1, 6'h00, 3'd2, 0, 0, 0);
    cyc("dec_cleared", 1, 0, 1, 6'h00, 3'd0, 0, 0, 0);
    for (int i = 0; i < 5 && q.size() != 0; i++)
      @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
